// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - NCH-channel bus timer: prescaled free-run/periodic/one-shot counters with compare and overflow
// Input capture is built only when TIMER_CAPTURE_EN is defined.
module multi_timer #(
   parameter int NCH = 4,
   parameter int CW  = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [15:0]    data_write,
   output logic [15:0]    data_read,
   input  logic [7:0]     addr,
   input  logic           uds,
   input  logic           lds,
   input  logic           rw,
   output logic           ack,
   input  logic [NCH-1:0] cap_in,
   output logic [NCH-1:0] match,
   output logic           irq
);

   logic [CW-1:0]  cnt    [NCH];
   logic [CW-1:0]  cmp    [NCH];
   logic [15:0]    shadow [NCH];
   logic [1:0]     mode   [NCH];
   logic [4:0]     ps     [NCH];
   logic [NCH-1:0] en, ie_match, ie_ovf, ie_cap;
   logic [NCH-1:0] st_match, st_ovf, st_cap;
   logic [NCH-1:0] tick, eq, hit, chsel, cap_rise;
   logic [31:0]    pre;
   logic [15:0]    rdata;
   logic           strb, access, rd_acc, wr_acc;
   logic [2:0]     word;

`ifdef TIMER_CAPTURE_EN
   logic [CW-1:0]  cap [NCH];
   logic [NCH-1:0] cap_s1, cap_s2, cap_s3;
   logic           unused_bits;
   assign cap_rise    = cap_s2 & ~cap_s3;
   assign unused_bits = addr[0];
`else
   logic           unused_bits;
   assign cap_rise    = '0;
   assign ie_cap      = '0;
   assign st_cap      = '0;
   assign unused_bits = ^{cap_in, addr[0]};
`endif

   function automatic logic [15:0] lane_merge(input logic [15:0] old, input logic [15:0] d,
                                              input logic hi_ln, input logic lo_ln);
      logic [15:0] r;
      r = old;
      if (hi_ln) r[15:8] = d[15:8];
      if (lo_ln) r[7:0] = d[7:0];
      return r;
   endfunction

   function automatic logic [15:0] hi16(input logic [CW-1:0] v);
      logic [31:0] t;
      t = 32'(v);
      return t[31:16];
   endfunction

   function automatic logic [15:0] lo16(input logic [CW-1:0] v);
      logic [31:0] t;
      t = 32'(v);
      return t[15:0];
   endfunction

   // Bits above CW fall off here, which is what makes upper-word writes ignored on narrow counters.
   function automatic logic [CW-1:0] wr16(input logic [CW-1:0] v, input logic upper,
                                          input logic [15:0] d, input logic hi_ln, input logic lo_ln);
      logic [31:0] t;
      t = 32'(v);
      if (upper) t[31:16] = lane_merge(t[31:16], d, hi_ln, lo_ln);
      else       t[15:0]  = lane_merge(t[15:0], d, hi_ln, lo_ln);
      return t[CW-1:0];
   endfunction

   // ack doubles as the registered strobe, so an access is the first strobed clk after an idle one.
   assign strb   = uds | lds;
   assign access = strb & ~ack;
   assign rd_acc = access & rw;
   assign wr_acc = access & ~rw;
   assign word   = addr[3:1];

   always_comb begin
      logic [31:0] mask;
      mask = '0;
      for (int i = 0; i < NCH; i++) begin
         mask     = (32'd1 << ps[i]) - 32'd1;
         tick[i]  = en[i] && ((pre & mask) == mask);
         eq[i]    = (cnt[i] == cmp[i]);
         hit[i]   = tick[i] & eq[i];
         chsel[i] = (addr[7:4] == 4'(i));
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (chsel[i]) begin
            case (word)
               3'd0:    rdata = hi16(cnt[i]);
               3'd1:    rdata = shadow[i];
               3'd2:    rdata = hi16(cmp[i]);
               3'd3:    rdata = lo16(cmp[i]);
               3'd4:    rdata = {5'd0, ie_cap[i], ie_ovf[i], ie_match[i], ps[i], mode[i], en[i]};
               3'd5:    rdata = {13'd0, st_cap[i], st_ovf[i], st_match[i]};
`ifdef TIMER_CAPTURE_EN
               3'd6:    rdata = hi16(cap[i]);
               3'd7:    rdata = lo16(cap[i]);
`endif
               default: rdata = '0;
            endcase
         end
      end
   end

   assign irq = |((st_match & ie_match) | (st_ovf & ie_ovf) | (st_cap & ie_cap));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre       <= '0;
         ack       <= 1'b0;
         data_read <= '0;
         match     <= '0;
         en        <= '0;
         ie_match  <= '0;
         ie_ovf    <= '0;
         st_match  <= '0;
         st_ovf    <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt[i]    <= '0;
            cmp[i]    <= '0;
            shadow[i] <= '0;
            mode[i]   <= '0;
            ps[i]     <= '0;
         end
`ifdef TIMER_CAPTURE_EN
         ie_cap <= '0;
         st_cap <= '0;
         cap_s1 <= '0;
         cap_s2 <= '0;
         cap_s3 <= '0;
         for (int i = 0; i < NCH; i++) cap[i] <= '0;
`endif
      end else begin
         pre   <= pre + 32'd1;
         ack   <= strb;
         match <= hit;
         if (rd_acc) data_read <= rdata;
`ifdef TIMER_CAPTURE_EN
         cap_s1 <= cap_in;
         cap_s2 <= cap_s1;
         cap_s3 <= cap_s2;
`endif
         for (int i = 0; i < NCH; i++) begin
            if (rd_acc && chsel[i] && word == 3'd0) shadow[i] <= lo16(cnt[i]);

            // W1C first so a same-clk hardware set below wins.
            if (wr_acc && chsel[i] && word == 3'd5 && lds) begin
               if (data_write[0]) st_match[i] <= 1'b0;
               if (data_write[1]) st_ovf[i]   <= 1'b0;
`ifdef TIMER_CAPTURE_EN
               if (data_write[2]) st_cap[i]   <= 1'b0;
`endif
            end

`ifdef TIMER_CAPTURE_EN
            if (cap_rise[i]) begin
               cap[i]    <= cnt[i];
               st_cap[i] <= 1'b1;
            end
`endif

            if (tick[i]) begin
               if (eq[i]) st_match[i] <= 1'b1;
               if (eq[i] && mode[i] != 2'b00) begin
                  cnt[i] <= '0;
                  if (mode[i] == 2'b10) en[i] <= 1'b0;
               end else begin
                  cnt[i] <= cnt[i] + CW'(1);
                  if (&cnt[i]) st_ovf[i] <= 1'b1;
               end
            end

            // Bus writes come last so they override the tick update on the same clk.
            if (wr_acc && chsel[i]) begin
               case (word)
                  3'd0: cnt[i] <= wr16(cnt[i], 1'b1, data_write, uds, lds);
                  3'd1: cnt[i] <= wr16(cnt[i], 1'b0, data_write, uds, lds);
                  3'd2: cmp[i] <= wr16(cmp[i], 1'b1, data_write, uds, lds);
                  3'd3: cmp[i] <= wr16(cmp[i], 1'b0, data_write, uds, lds);
                  3'd4: begin
                     if (lds) begin
                        en[i]   <= data_write[0];
                        mode[i] <= data_write[2:1];
                        ps[i]   <= data_write[7:3];
                     end
                     if (uds) begin
                        ie_match[i] <= data_write[8];
                        ie_ovf[i]   <= data_write[9];
`ifdef TIMER_CAPTURE_EN
                        ie_cap[i]   <= data_write[10];
`endif
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed self-checking bench for multi_timer (default build or TIMER_CAPTURE_EN)
`timescale 1ns/1ps
module tb_multi_timer;

   localparam int NCH = 4;
`ifdef TIMER_CAPTURE_EN
   localparam logic [15:0] CTRL_ALL = 16'h07FE;
   localparam logic [15:0] CAP_LO   = 16'h0020;
   localparam logic [15:0] CAP_STAT = 16'h0004;
`else
   localparam logic [15:0] CTRL_ALL = 16'h03FE;
   localparam logic [15:0] CAP_LO   = 16'h0000;
   localparam logic [15:0] CAP_STAT = 16'h0000;
`endif

   logic           clk = 1'b0;
   logic           reset_n;
   logic [15:0]    data_write, data_read;
   logic [7:0]     addr;
   logic           uds, lds, rw, ack, irq;
   logic [NCH-1:0] cap_in, match;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_acc = 0;

   multi_timer #(.NCH(NCH), .CW(32)) dut (
      .clk(clk), .reset_n(reset_n), .data_write(data_write), .data_read(data_read),
      .addr(addr), .uds(uds), .lds(lds), .rw(rw), .ack(ack),
      .cap_in(cap_in), .match(match), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // All bus tasks are entered and left at a negedge.
   task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
      addr = a; data_write = d; rw = 1'b0; uds = 1'b1; lds = 1'b1;
      @(posedge clk); @(negedge clk);
      last_acc = cyc;
      uds = 1'b0; lds = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic bus_read(input logic [7:0] a, input int hold, output logic [15:0] d,
                           output int acks, output logic ack_end);
      addr = a; rw = 1'b1; uds = 1'b1; lds = 1'b1;
      acks = 0;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); @(negedge clk);
         if (ack) acks++;
         d = data_read;
      end
      uds = 1'b0; lds = 1'b0;
      @(posedge clk); @(negedge clk);
      ack_end = ack;
   endtask

   task automatic rd_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
      logic [15:0] d;
      int          acks;
      logic        ae;
      bus_read(a, 1, d, acks, ae);
      check_eq(tag, {16'd0, d}, {16'd0, exp});
   endtask

   task automatic wait_match(input int ch, input int lim, output int when);
      when = -1000;
      for (int k = 0; k < lim; k++) begin
         @(posedge clk); @(negedge clk);
         if (match[ch]) begin
            when = cyc;
            break;
         end
      end
   endtask

   initial begin
      logic [15:0] d;
      int          acks, t0, t1, t2, t3, tm, npulse, first;
      logic        ae;

      reset_n = 1'b0; data_write = '0; addr = '0; uds = 1'b0; lds = 1'b0; rw = 1'b1; cap_in = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_data_read", {16'd0, data_read}, 32'd0);
      check_eq("rst_ack", {31'd0, ack}, 32'd0);
      check_eq("rst_match", {28'd0, match}, 32'd0);
      check_eq("rst_irq", {31'd0, irq}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int ch = 0; ch < NCH; ch++) begin
         for (int w = 0; w < 8; w++) begin
            bus_read(8'((ch << 4) | (w << 1)), 1, d, acks, ae);
            check_eq($sformatf("rst_rd_c%0d_w%0d", ch, w), {16'd0, d}, 32'd0);
            check_eq($sformatf("rst_ack_c%0d_w%0d", ch, w), acks, 1);
            check_eq($sformatf("rst_ackdrop_c%0d_w%0d", ch, w), {31'd0, ae}, 32'd0);
         end
      end
      bus_write(8'h46, 16'h1234);
      bus_read(8'h46, 1, d, acks, ae);
      check_eq("chNCH_rd", {16'd0, d}, 32'd0);
      check_eq("chNCH_ack", acks, 1);

      bus_write(8'h08, 16'hFFFE);
      rd_check("ctrl_bits_rd", 8'h08, CTRL_ALL);
      bus_write(8'h08, 16'h0000);

      // ch1 periodic, CMP=4: match every 5 clk
      bus_write(8'h14, 16'h0000);
      bus_write(8'h16, 16'h0004);
      bus_write(8'h18, 16'h0103);
      wait_match(1, 20, t1);
      check_eq("ch1_first_delay", t1 - last_acc, 5);
      wait_match(1, 20, t2);
      check_eq("ch1_period_a", t2 - t1, 5);
      check_eq("ch1_irq_set", {31'd0, irq}, 32'd1);
      @(posedge clk); @(negedge clk);
      check_eq("ch1_pulse_width", {31'd0, match[1]}, 32'd0);
      wait_match(1, 20, t3);
      check_eq("ch1_period_b", t3 - t2, 5);
      bus_write(8'h1A, 16'h0001);
      check_eq("ch1_irq_cleared", {31'd0, irq}, 32'd0);
      wait_match(1, 20, tm);
      check_eq("ch1_period_c", tm - t3, 5);
      check_eq("ch1_irq_again", {31'd0, irq}, 32'd1);
      bus_write(8'h18, 16'h0000);
      bus_write(8'h1A, 16'h0001);
      check_eq("ch1_irq_off", {31'd0, irq}, 32'd0);

      // ch0 free-run PS=2 from 0xFFFFFFFE: overflow, then match at 0x10
      bus_write(8'h04, 16'h0000);
      bus_write(8'h06, 16'h0010);
      bus_write(8'h00, 16'hFFFF);
      bus_write(8'h02, 16'hFFFE);
      bus_write(8'h08, 16'h0211);
      t0 = -1000;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); @(negedge clk);
         if (irq) begin
            t0 = cyc;
            break;
         end
      end
      check_eq("ch0_ovf_window", {31'd0, (t0 - last_acc >= 5) && (t0 - last_acc <= 8)}, 32'd1);
      rd_check("ch0_cnt_hi_wrap", 8'h00, 16'h0000);
      rd_check("ch0_cnt_lo_wrap", 8'h02, 16'h0000);
      rd_check("ch0_stat_ovf", 8'h0A, 16'h0002);
      wait_match(0, 100, tm);
      check_eq("ch0_match_delay", tm - t0, 68);
      rd_check("ch0_cnt_hi_after", 8'h00, 16'h0000);
      rd_check("ch0_cnt_lo_after", 8'h02, 16'h0011);
      rd_check("ch0_stat_both", 8'h0A, 16'h0003);
      bus_write(8'h08, 16'h0000);
      bus_write(8'h0A, 16'h0003);
      check_eq("ch0_irq_off", {31'd0, irq}, 32'd0);

      // ch2 one-shot CMP=3
      bus_write(8'h26, 16'h0003);
      bus_write(8'h28, 16'h0005);
      npulse = 0;
      first  = -1000;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); @(negedge clk);
         if (match[2]) begin
            if (npulse == 0) first = cyc;
            npulse++;
         end
      end
      check_eq("ch2_pulses", npulse, 1);
      check_eq("ch2_match_delay", first - last_acc, 4);
      rd_check("ch2_ctrl_en_clr", 8'h28, 16'h0004);
      rd_check("ch2_cnt_hi", 8'h20, 16'h0000);
      rd_check("ch2_cnt_lo", 8'h22, 16'h0000);
      rd_check("ch2_stat", 8'h2A, 16'h0001);

      // ch3 counting at PS=0: hi/lo shadow with strobes held 5 clk
      bus_write(8'h34, 16'hFFFF);
      bus_write(8'h36, 16'hFFFF);
      bus_write(8'h30, 16'h0001);
      bus_write(8'h32, 16'hFFFE);
      bus_write(8'h38, 16'h0001);
      bus_read(8'h30, 5, d, acks, ae);
      check_eq("hold_cnt_hi", {16'd0, d}, 32'h0001);
      check_eq("hold_ack_cycles", acks, 5);
      check_eq("hold_ack_drop", {31'd0, ae}, 32'd0);
      rd_check("hold_cnt_lo_shadow", 8'h32, 16'hFFFF);
      bus_write(8'h38, 16'h0000);

      // capture on ch3 with CNT frozen at 0x20
      bus_write(8'h30, 16'h0000);
      bus_write(8'h32, 16'h0020);
      rd_check("cap_stat_before", 8'h3A, 16'h0000);
      cap_in[3] = 1'b1;
      repeat (5) @(negedge clk);
      cap_in[3] = 1'b0;
      repeat (2) @(negedge clk);
      rd_check("cap_hi", 8'h3C, 16'h0000);
      rd_check("cap_lo", 8'h3E, CAP_LO);
      rd_check("cap_stat", 8'h3A, CAP_STAT);
      check_eq("cap_irq", {31'd0, irq}, 32'd0);

      // async reset in the middle of a transfer
      bus_write(8'h18, 16'h0101);
      addr = 8'h10; rw = 1'b1; uds = 1'b1; lds = 1'b1;
      @(posedge clk); @(negedge clk);
      check_eq("mid_ack_high", {31'd0, ack}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("mid_rst_ack", {31'd0, ack}, 32'd0);
      check_eq("mid_rst_match", {28'd0, match}, 32'd0);
      uds = 1'b0; lds = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd_check("mid_rst_ctrl", 8'h18, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
